// File: rtl/bwn_pkg.sv
// bwn_pkg
// Shared definitions for the binary-weight network back end: default class
// count and score width, clamp limits for the packed scores, a saturating
// score helper and a ceil-log2 helper for counter widths.
package bwn_pkg;

    localparam int DFLT_CLASS_NUM = 3;
    localparam int DFLT_D_WL      = 16;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Scores are kept within one quarter of the D_WL range so that the
    // judge's D_WL-bit pairwise differences can never overflow.
    function automatic logic signed [63:0] score_max(input int unsigned d_wl);
        return (64'sd1 <<< (d_wl - 2)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] score_min(input int unsigned d_wl);
        return -(64'sd1 <<< (d_wl - 2));
    endfunction

    localparam logic signed [63:0] SCORE_MAX = score_max(DFLT_D_WL);
    localparam logic signed [63:0] SCORE_MIN = score_min(DFLT_D_WL);

    // Clamp a wide signed value into the score range for width d_wl.
    // The result is still 64 bits wide; callers truncate to d_wl.
    function automatic logic signed [63:0] sat_score(input logic signed [63:0] v,
                                                     input int unsigned d_wl);
        if (v > score_max(d_wl)) begin
            return score_max(d_wl);
        end
        if (v < score_min(d_wl)) begin
            return score_min(d_wl);
        end
        return v;
    endfunction

endpackage

// File: rtl/score_acc.sv
// score_acc
// Single-class signed accumulator with output clamp.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of the accumulator (wins over en)
//   first       current beat is the first of a class: load instead of add
//   en          accept din this cycle
//   din         signed partial sum, D_WL bits
//   score       clamped value of the running sum including din (combinational)
module score_acc
    import bwn_pkg::*;
#(
    parameter int D_WL    = DFLT_D_WL,
    parameter int ACC_LEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            first,
    input  logic            en,
    input  logic [D_WL-1:0] din,
    output logic [D_WL-1:0] score
);

    // Wide enough that ACC_LEN full-scale beats cannot overflow.
    localparam int AW = D_WL + clog2(ACC_LEN);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] din_ext;
    logic signed [AW-1:0] sum;

    assign din_ext = AW'($signed(din));

    always_comb begin
        sum = acc + din_ext;
        if (first) begin
            sum = din_ext;
        end
    end

    // On the final beat of a class this is the clamped class score.
    assign score = D_WL'(sat_score(64'(sum), D_WL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/class_score_packer.sv
// class_score_packer
// Accumulates class-major serial partial sums from the last FC layer into one
// clamped signed score per class and packs them for the argmax judge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    in_data beat valid
//   in_data     signed partial sum, D_WL bits
//   clear       synchronous frame abort (wins over in_valid)
//   data        packed scores, class k at [(k+1)*D_WL-1 : k*D_WL]; held between frames
//   o_valid     one-cycle pulse when data has been updated
//   busy        a frame is partially received
module class_score_packer
    import bwn_pkg::*;
#(
    parameter int CLASS_NUM = DFLT_CLASS_NUM,
    parameter int D_WL      = DFLT_D_WL,
    parameter int ACC_LEN   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [D_WL-1:0]           in_data,
    input  logic                      clear,
    output logic [CLASS_NUM*D_WL-1:0] data,
    output logic                      o_valid,
    output logic                      busy
);

    localparam int BW = (clog2(ACC_LEN) < 1) ? 1 : clog2(ACC_LEN);
    localparam int CW = (clog2(CLASS_NUM) < 1) ? 1 : clog2(CLASS_NUM);

    logic [BW-1:0]   beat_cnt;
    logic [CW-1:0]   cls_cnt;
    logic            accept;
    logic            first_beat;
    logic            last_beat;
    logic            last_cls;
    logic [D_WL-1:0] score;
    logic [D_WL-1:0] slot [CLASS_NUM-1];

    assign accept     = in_valid & ~clear;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == BW'(ACC_LEN - 1));
    assign last_cls   = (cls_cnt == CW'(CLASS_NUM - 1));
    assign busy       = (cls_cnt != '0) | (beat_cnt != '0);

    score_acc #(
        .D_WL    (D_WL),
        .ACC_LEN (ACC_LEN)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .first (first_beat),
        .en    (accept),
        .din   (in_data),
        .score (score)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            cls_cnt  <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            cls_cnt  <= '0;
        end else if (accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
                cls_cnt  <= last_cls ? '0 : cls_cnt + CW'(1);
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    // Classes 0..CLASS_NUM-2 park here until the last class completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CLASS_NUM - 1; k++) begin
                slot[k] <= '0;
            end
        end else if (clear) begin
            for (int unsigned k = 0; k < CLASS_NUM - 1; k++) begin
                slot[k] <= '0;
            end
        end else if (accept && last_beat && !last_cls) begin
            slot[cls_cnt] <= score;
        end
    end

    // The last class bypasses the slots and is packed straight from the clamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (accept && last_beat && last_cls) begin
                o_valid <= 1'b1;
                for (int unsigned k = 0; k < CLASS_NUM - 1; k++) begin
                    data[k*D_WL +: D_WL] <= slot[k];
                end
                data[(CLASS_NUM-1)*D_WL +: D_WL] <= score;
            end
        end
    end

endmodule

// File: doc/class_score_packer.md
# class_score_packer

Accumulates the serial per-class partial sums from the final binary-weight FC layer into one signed score per class. Packs the scores into the `CLASS_NUM*D_WL` vector consumed by the argmax judge stage. Emits that vector with a one-cycle valid pulse per completed frame. Sits between the last FC MAC array and the judge, and drives the judge's `data` / `in_valid` inputs directly.

## Interface
- `CLASS_NUM`, 3, number of classes / score slots
- `D_WL`, 16, width of each input partial sum and each packed output score, signed two's complement
- `ACC_LEN`, 16, partial sums per class per frame (≥2)
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  `in_data` beat is valid this cycle
- `in_data`  in  `D_WL`  signed partial sum
- `clear`  in  1  synchronous frame abort
- `data`  out  `CLASS_NUM*D_WL`  packed scores; class k at bits `[(k+1)*D_WL-1 : k*D_WL]`
- `o_valid`  out  1  one-cycle pulse: `data` updated this cycle
- `busy`  out  1  frame in progress (at least one beat accepted, frame not yet complete)

## Operation
- Beats arrive class-major: `ACC_LEN` beats for class 0, then class 1, … up to class `CLASS_NUM-1`. No sideband framing; position comes from internal counters.
- Counters:
  - `beat_cnt` runs 0..`ACC_LEN-1`.
  - `cls_cnt` runs 0..`CLASS_NUM-1`.
  - Both advance only on accepted beats. Gaps (`in_valid`=0) are allowed anywhere and hold all state.
- Accumulator:
  - Signed, width `D_WL+clog2(ACC_LEN)`, so no internal overflow.
  - Loaded with sign-extended `in_data` on beat 0 of a class; adds `in_data` on every later beat.
- Class completion (beat `ACC_LEN-1`):
  - The final sum (acc+`in_data`) is clamped to [-2^(D_WL-2), 2^(D_WL-2)-1] (default −16384..16383).
  - The clamp guarantees the judge's `D_WL`-bit pairwise differences never overflow.
  - Classes 0..`CLASS_NUM-2` are written into internal slot registers.
- Frame completion (last beat of class `CLASS_NUM-1`):
  - `data` ← {clamped last class, slots}.
  - `o_valid` pulses; counters return to 0.
- `data` holds its value until the next frame completes. The next frame may accumulate while the judge samples.
- `clear`=1:
  - Counters, accumulator and slots go to 0; `busy` drops.
  - `data` is unchanged; no `o_valid` is produced.
  - `clear` wins over a simultaneous `in_valid`; that beat is discarded.
- `busy` = (`cls_cnt`≠0 or `beat_cnt`≠0).

## Timing
- Reset values: `data`=0, `o_valid`=0, `busy`=0; counters, accumulator and slots all 0.
- Latency: `o_valid` and new `data` appear one cycle after the clock edge that accepts the frame's final beat.
- `o_valid` is high exactly one cycle per frame and is never asserted on two consecutive cycles unless frames are shorter than 2 beats, which is excluded by `ACC_LEN`≥2.
- Back-to-back frames:
  - Beat 0 of frame N+1 may arrive the cycle after the last beat of frame N.
  - It is accepted normally, and `o_valid` for frame N fires in that same cycle.
- Minimum frame period is `CLASS_NUM*ACC_LEN` cycles; throughput is one beat per cycle.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The partial frame is lost and no `o_valid` is produced.
- No backpressure; the downstream judge accepts on every `o_valid`.

## Structure
- Shared package `bwn_pkg`:
  - `CLASS_NUM`, `D_WL` defaults.
  - Clamp limits `SCORE_MAX`/`SCORE_MIN` as functions of `D_WL`.
  - A `sat_score` function (wide signed → clamped `D_WL`).
  - Counter-width helpers (`clog2`).
- One sub-module: `score_acc`, the single-class accumulator plus clamp.
  - Inputs: `clk`, `rst_n`, `clr`, `first`, `en`, `din`.
  - Output: clamped `D_WL` sum.
- Counters, slots and packing stay in the top level.

## Test plan
(Parameters for all tests: `CLASS_NUM`=3, `D_WL`=16, `ACC_LEN`=4.)
- Basic frame:
  - Stimulus: class0 beats 1,2,3,4; class1 beats 10,10,10,10; class2 beats −5,0,0,0, contiguous.
  - Response: one cycle after the 12th beat, `o_valid`=1 and `data`={16'hFFFB,16'd40,16'd10}; the judge then outputs 2'b10.
- Gaps:
  - Stimulus: same frame with `in_valid` deasserted for 3 cycles between random beats.
  - Response: identical `data`; `o_valid` one cycle after the last beat; `busy` high throughout.
- Saturation:
  - Stimulus: class0 beats 4×16'h7FFF; class1 beats 4×16'h8000; class2 beats 0.
  - Response: class0=16383, class1=−16384, class2=0; the judge selects class 0 (2'b01).
- Back-to-back and data hold:
  - Stimulus: two 12-beat frames with no gap.
  - Response: `o_valid` pulses exactly twice, 12 cycles apart. `data` stays constant between pulses while frame 2 accumulates.
- `clear`:
  - Stimulus: assert `clear` together with beat 6 of a frame.
  - Response: no `o_valid`, `busy`=0 next cycle, old `data` retained. A following full frame produces correct sums with no residue.
- Async reset:
  - Stimulus: drop `rst_n` mid-class 1.
  - Response: `data`=0, `o_valid`=0, `busy`=0 immediately. A subsequent frame is correct.
